// File: rtl/codec_config_pkg.sv
// rtl/codec_config_pkg.sv - shared constants, register table and FSM encoding for codec_config
// Contents: DEV_ADDR (codec write address), TABLE_LEN, TABLE_WORDS ({reg[6:0], data[8:0]}),
//           REG_R2/REG_R3 (volume registers), state_t (sequencer states), table_word() lookup.
package codec_config_pkg;

    localparam logic [7:0] DEV_ADDR  = 8'h34;
    localparam int         TABLE_LEN = 10;

    localparam logic [6:0] REG_R2 = 7'd2;
    localparam logic [6:0] REG_R3 = 7'd3;

    // Each word is {register[6:0], data[8:0]}; R15 first resets the codec.
    localparam logic [15:0] TABLE_WORDS [0:TABLE_LEN-1] = '{
        {7'd15, 9'h000},
        {7'd0,  9'h017},
        {7'd1,  9'h017},
        {7'd2,  9'h079},
        {7'd3,  9'h079},
        {7'd4,  9'h012},
        {7'd5,  9'h000},
        {7'd6,  9'h000},
        {7'd7,  9'h002},
        {7'd9,  9'h001}
    };

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_GAP,
        ST_NEXT,
        ST_DONE,
        ST_FAIL
    } state_t;

    function automatic logic [15:0] table_word(input logic [3:0] idx);
        if (idx < 4'(TABLE_LEN)) begin
            table_word = TABLE_WORDS[idx];
        end else begin
            table_word = 16'h0000;
        end
    endfunction

endpackage

// File: rtl/codec_config_byte_tx.sv
// rtl/codec_config_byte_tx.sv - tick-driven I2C byte shifter with ACK sample (module i2c_byte_tx)
// Ports: clk, reset (sync, active-high), tick (quarter-bit strobe), start/data (load a byte when
//        ready), sda (synchronised SDA level), ready (idle), ack_phase (9th bit in progress),
//        ack_ok (last ACK result), scl/sda_oe (bus drive while not ready).
module i2c_byte_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       sda,
    output logic       ready,
    output logic       ack_phase,
    output logic       ack_ok,
    output logic       scl,
    output logic       sda_oe
);

    logic       active;
    logic [7:0] shift;
    logic [3:0] bit_cnt;
    logic [1:0] quarter;

    assign ready     = !active;
    assign ack_phase = active && (bit_cnt == 4'd8);

    // Bit slots 0..7 carry data MSB first, slot 8 is the released ACK slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            shift   <= 8'h00;
            bit_cnt <= 4'd0;
            quarter <= 2'd0;
            ack_ok  <= 1'b0;
            scl     <= 1'b1;
            sda_oe  <= 1'b0;
        end else if (!active) begin
            if (start) begin
                active  <= 1'b1;
                shift   <= data;
                bit_cnt <= 4'd0;
                quarter <= 2'd0;
                // Matches the level the sequencer leaves after START / a previous byte.
                scl     <= 1'b0;
                sda_oe  <= 1'b1;
            end
        end else if (tick) begin
            case (quarter)
                2'd0: begin
                    scl    <= 1'b0;
                    sda_oe <= (bit_cnt == 4'd8) ? 1'b0 : !shift[7];
                end
                2'd1: scl <= 1'b1;
                2'd2: begin
                    if (bit_cnt == 4'd8) begin
                        ack_ok <= !sda;
                    end
                end
                default: begin
                    scl <= 1'b0;
                    if (bit_cnt == 4'd8) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        shift   <= {shift[6:0], 1'b0};
                    end
                end
            endcase
            quarter <= quarter + 2'd1;
        end
    end

endmodule

// File: rtl/codec_config.sv
// rtl/codec_config.sv - I2C register-table loader and volume updater for an audio codec
// Ports: clk18, reset (sync, active-high), start (full table), vol/vol_upd (volume write),
//        i2c_sclk (push-pull SCL), i2c_sdat_oe (1 = pull SDA low), i2c_sdat_in (SDA pad level),
//        busy, done, error (status levels).
module codec_config
    import codec_config_pkg::*;
#(
    parameter int CLK_DIV   = 45,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk18,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] vol,
    input  logic       vol_upd,
    output logic       i2c_sclk,
    output logic       i2c_sdat_oe,
    input  logic       i2c_sdat_in,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             sda_meta;
    logic             sda_sync;
    logic [1:0]       step;
    logic [1:0]       byte_idx;
    logic [3:0]       index;
    logic [RTY_W-1:0] retry_cnt;
    logic             retry_flag;
    logic             vol_mode;
    logic [6:0]       vol_cur;
    logic [6:0]       pend_vol;
    logic             pending;
    logic             configured;
    logic             scl_r;
    logic             oe_r;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic [15:0]      cur_word;
    logic             tx_ready;
    logic             tx_ack_phase;
    logic             tx_ack_ok;
    logic             tx_scl;
    logic             tx_oe;
    logic             seq_last;
    logic             vol_req;

    // Divider is held at 0 while idle, so every sequence starts on a fresh count.
    always_ff @(posedge clk18) begin
        if (reset || !busy) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = busy && (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk18) begin
        if (reset) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= i2c_sdat_in;
            sda_sync <= sda_meta;
        end
    end

    always_comb begin
        cur_word = table_word(index);
        if (vol_mode) begin
            cur_word = {(index == 4'd0) ? REG_R2 : REG_R3, 2'b01, vol_cur};
        end
        case (byte_idx)
            2'd0:    tx_data = DEV_ADDR;
            2'd1:    tx_data = cur_word[15:8];
            default: tx_data = cur_word[7:0];
        endcase
    end

    assign seq_last = vol_mode ? (index == 4'd1) : (index == 4'(TABLE_LEN - 1));
    assign vol_req  = vol_upd && configured;

    i2c_byte_tx u_byte_tx (
        .clk       (clk18),
        .reset     (reset),
        .tick      (tick),
        .start     (tx_start),
        .data      (tx_data),
        .sda       (sda_sync),
        .ready     (tx_ready),
        .ack_phase (tx_ack_phase),
        .ack_ok    (tx_ack_ok),
        .scl       (tx_scl),
        .sda_oe    (tx_oe)
    );

    // The shifter owns the pins only while it has a byte in flight.
    assign i2c_sclk    = tx_ready ? scl_r : tx_scl;
    assign i2c_sdat_oe = tx_ready ? oe_r  : tx_oe;

    always_ff @(posedge clk18) begin
        if (reset) begin
            state      <= ST_IDLE;
            step       <= 2'd0;
            byte_idx   <= 2'd0;
            index      <= 4'd0;
            retry_cnt  <= '0;
            retry_flag <= 1'b0;
            vol_mode   <= 1'b0;
            vol_cur    <= 7'd0;
            pend_vol   <= 7'd0;
            pending    <= 1'b0;
            configured <= 1'b0;
            scl_r      <= 1'b1;
            oe_r       <= 1'b0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            tx_start <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // start wins over a simultaneous or pending volume request.
                    if (start || vol_req || pending) begin
                        state      <= ST_START;
                        busy       <= 1'b1;
                        step       <= 2'd0;
                        index      <= 4'd0;
                        retry_cnt  <= '0;
                        retry_flag <= 1'b0;
                        vol_mode   <= !start;
                        if (start) begin
                            done  <= 1'b0;
                            error <= 1'b0;
                        end else begin
                            vol_cur <= vol_req ? vol : pend_vol;
                            pending <= 1'b0;
                        end
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (step == 2'd0) begin
                            oe_r <= 1'b1;
                            step <= 2'd1;
                        end else begin
                            scl_r    <= 1'b0;
                            step     <= 2'd0;
                            byte_idx <= 2'd0;
                            tx_start <= 1'b1;
                            state    <= ST_BIT;
                        end
                    end
                end

                ST_BIT: begin
                    if (tx_ack_phase) begin
                        state <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    if (tx_ready) begin
                        step <= 2'd0;
                        if (!tx_ack_ok) begin
                            retry_flag <= 1'b1;
                            state      <= ST_STOP;
                        end else if (byte_idx == 2'd2) begin
                            state <= ST_STOP;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            tx_start <= 1'b1;
                            state    <= ST_BIT;
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        case (step)
                            2'd0: begin
                                oe_r <= 1'b1;
                                step <= 2'd1;
                            end
                            2'd1: begin
                                scl_r <= 1'b1;
                                step  <= 2'd2;
                            end
                            default: begin
                                oe_r  <= 1'b0;
                                step  <= 2'd0;
                                state <= ST_GAP;
                            end
                        endcase
                    end
                end

                ST_GAP: begin
                    if (tick) begin
                        if (step == 2'd3) begin
                            step  <= 2'd0;
                            state <= ST_NEXT;
                        end else begin
                            step <= step + 2'd1;
                        end
                    end
                end

                ST_NEXT: begin
                    step <= 2'd0;
                    if (retry_flag) begin
                        retry_flag <= 1'b0;
                        if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ST_START;
                        end else begin
                            busy  <= 1'b0;
                            error <= 1'b1;
                            state <= ST_FAIL;
                        end
                    end else begin
                        retry_cnt <= '0;
                        if (seq_last) begin
                            busy  <= 1'b0;
                            state <= ST_DONE;
                            if (!vol_mode) begin
                                done       <= 1'b1;
                                configured <= 1'b1;
                            end
                        end else begin
                            index <= index + 4'd1;
                            state <= ST_START;
                        end
                    end
                end

                ST_DONE: state <= ST_IDLE;
                ST_FAIL: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Requests outside IDLE collapse into one pending update with the newest volume.
            if (state != ST_IDLE && vol_req) begin
                pending  <= 1'b1;
                pend_vol <= vol;
            end
        end
    end

endmodule

// File: tb/tb_codec_config.sv
// tb/tb_codec_config.sv - self-checking bench for codec_config with an I2C slave model
module tb_codec_config;

    logic       clk18 = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] vol = 7'd0;
    logic       vol_upd = 1'b0;
    logic       i2c_sclk;
    logic       i2c_sdat_oe;
    logic       sda_in;
    logic       busy;
    logic       done;
    logic       error;
    logic       slave_oe = 1'b0;

    int errors = 0;
    int checks = 0;

    // Frame format: {bytes_received[1:0], byte0, byte1, byte2}
    logic [25:0] exp_q[$];
    logic [25:0] obs_q[$];

    bit         nack_addr = 1'b0;
    logic [7:0] nack_val  = 8'h06;
    int         nack_left = 0;

    assign sda_in = !(i2c_sdat_oe || slave_oe);

    always #5 clk18 = ~clk18;

    codec_config #(.CLK_DIV(4), .MAX_RETRY(3)) dut (
        .clk18       (clk18),
        .reset       (reset),
        .start       (start),
        .vol         (vol),
        .vol_upd     (vol_upd),
        .i2c_sclk    (i2c_sclk),
        .i2c_sdat_oe (i2c_sdat_oe),
        .i2c_sdat_in (sda_in),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    // I2C slave model: decodes START/STOP/bits, ACKs unless told to NACK.
    logic        scl_p = 1'b1, sda_p = 1'b1, in_frame = 1'b0, ack_ph = 1'b0;
    int          nbits = 0, nbytes = 0;
    logic [7:0]  shreg = 8'h00;
    logic [23:0] fb = 24'h0;

    always @(negedge clk18) begin
        logic scl_n, sda_n, nack;
        scl_n = i2c_sclk;
        sda_n = sda_in;
        if (reset) begin
            in_frame = 1'b0;
            ack_ph   = 1'b0;
            slave_oe = 1'b0;
            nbits    = 0;
        end else if (scl_p && scl_n && sda_p && !sda_n) begin
            in_frame = 1'b1;
            ack_ph   = 1'b0;
            slave_oe = 1'b0;
            nbits    = 0;
            nbytes   = 0;
            fb       = 24'h0;
        end else if (scl_p && scl_n && !sda_p && sda_n) begin
            if (in_frame) obs_q.push_back({2'(nbytes), fb});
            in_frame = 1'b0;
        end else if (!scl_p && scl_n) begin
            if (in_frame && !ack_ph && nbits < 8) begin
                shreg = {shreg[6:0], sda_n};
                nbits++;
            end
        end else if (scl_p && !scl_n && in_frame) begin
            if (ack_ph) begin
                ack_ph   = 1'b0;
                slave_oe = 1'b0;
                nbits    = 0;
            end else if (nbits == 8) begin
                ack_ph = 1'b1;
                case (nbytes)
                    0:       fb[23:16] = shreg;
                    1:       fb[15:8]  = shreg;
                    default: fb[7:0]   = shreg;
                endcase
                nbytes++;
                nack = 1'b0;
                if (nack_addr && nbytes == 1) nack = 1'b1;
                if (nbytes == 2 && shreg == nack_val && nack_left > 0) begin
                    nack = 1'b1;
                    nack_left--;
                end
                slave_oe = !nack;
            end
        end
        scl_p = scl_n;
        sda_p = sda_n;
    end

    function automatic logic [25:0] mk(input logic [6:0] r, input logic [8:0] d);
        mk = {2'd3, 8'h34, r, d[8], d[7:0]};
    endfunction

    function automatic logic [25:0] exp_word(input int i);
        case (i)
            0:       exp_word = mk(7'd15, 9'h000);
            1:       exp_word = mk(7'd0,  9'h017);
            2:       exp_word = mk(7'd1,  9'h017);
            3:       exp_word = mk(7'd2,  9'h079);
            4:       exp_word = mk(7'd3,  9'h079);
            5:       exp_word = mk(7'd4,  9'h012);
            6:       exp_word = mk(7'd5,  9'h000);
            7:       exp_word = mk(7'd6,  9'h000);
            8:       exp_word = mk(7'd7,  9'h002);
            default: exp_word = mk(7'd9,  9'h001);
        endcase
    endfunction

    task automatic get_frame(output logic [25:0] f, output bit got);
        got = 1'b0;
        f   = '0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk18);
            if (obs_q.size() > 0) begin
                f   = obs_q.pop_front();
                got = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk18);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk18);
        start = 1'b1;
        @(negedge clk18);
        start = 1'b0;
    endtask

    task automatic pulse_vol(input logic [6:0] v);
        @(negedge clk18);
        vol     = v;
        vol_upd = 1'b1;
        @(negedge clk18);
        vol_upd = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk18);
        checks++; if (i2c_sclk !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b expected 1", i2c_sclk); end
        checks++; if (i2c_sdat_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", i2c_sdat_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
        reset = 1'b0;
        repeat (200) @(negedge clk18);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            errors++; $display("FAIL no_auto_start: busy=%b frames=%0d expected idle", busy, obs_q.size());
        end
    endtask

    task automatic test_vol_before_done();
        bit activity = 1'b0;
        pulse_vol(7'h22);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk18);
            if (busy || !i2c_sclk || i2c_sdat_oe) activity = 1'b1;
        end
        checks++;
        if (activity || obs_q.size() != 0) begin
            errors++; $display("FAIL vol_unconfigured: activity=%b frames=%0d expected none", activity, obs_q.size());
        end
    endtask

    task automatic test_table();
        logic [25:0] f, e;
        bit got, ok;
        for (int i = 0; i < 10; i++) exp_q.push_back(exp_word(i));
        pulse_start();
        while (exp_q.size() > 0) begin
            get_frame(f, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || f !== e) begin
                errors++; $display("FAIL table_frame: got %h (seen=%0d) expected %h", f, got, e);
                if (!got) exp_q.delete();
            end
        end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL table_idle: busy stuck at %b expected 0", busy); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL table_done: got %b expected 1", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL table_error: got %b expected 0", error); end
    endtask

    task automatic test_vol();
        logic [25:0] f, e;
        bit got, ok;
        exp_q.push_back(mk(7'd2, {2'b01, 7'h5A}));
        exp_q.push_back(mk(7'd3, {2'b01, 7'h5A}));
        pulse_vol(7'h5A);
        while (exp_q.size() > 0) begin
            get_frame(f, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || f !== e) begin
                errors++; $display("FAIL vol_frame: got %h (seen=%0d) expected %h", f, got, e);
                if (!got) exp_q.delete();
            end
        end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL vol_idle: busy stuck at %b expected 0", busy); end

        exp_q.push_back(mk(7'd2, {2'b01, 7'h33}));
        exp_q.push_back(mk(7'd3, {2'b01, 7'h33}));
        exp_q.push_back(mk(7'd2, {2'b01, 7'h20}));
        exp_q.push_back(mk(7'd3, {2'b01, 7'h20}));
        pulse_vol(7'h33);
        repeat (40) @(negedge clk18);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vol_busy: got %b expected 1", busy); end
        pulse_vol(7'h10);
        repeat (40) @(negedge clk18);
        pulse_vol(7'h20);
        while (exp_q.size() > 0) begin
            get_frame(f, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || f !== e) begin
                errors++; $display("FAIL vol_pending_frame: got %h (seen=%0d) expected %h", f, got, e);
                if (!got) exp_q.delete();
            end
        end
        wait_idle(ok);
        repeat (1500) @(negedge clk18);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            errors++; $display("FAIL vol_single_followup: busy=%b extra_frames=%0d expected 0/0", busy, obs_q.size());
        end
    endtask

    task automatic test_start_and_vol();
        logic [25:0] f, e;
        bit got, ok;
        for (int i = 0; i < 10; i++) exp_q.push_back(exp_word(i));
        @(negedge clk18);
        start = 1'b1; vol_upd = 1'b1; vol = 7'h7F;
        @(negedge clk18);
        start = 1'b0; vol_upd = 1'b0;
        while (exp_q.size() > 0) begin
            get_frame(f, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || f !== e) begin
                errors++; $display("FAIL same_cycle_frame: got %h (seen=%0d) expected %h", f, got, e);
                if (!got) exp_q.delete();
            end
        end
        wait_idle(ok);
        repeat (1500) @(negedge clk18);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0 || done !== 1'b1) begin
            errors++; $display("FAIL same_cycle_vol_dropped: busy=%b frames=%0d done=%b expected 0/0/1", busy, obs_q.size(), done);
        end
    endtask

    task automatic test_nack_retry();
        logic [25:0] f, e;
        bit got, ok;
        nack_val  = 8'h06;
        nack_left = 2;
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_word(i));
        exp_q.push_back({2'd2, 8'h34, 8'h06, 8'h00});
        exp_q.push_back({2'd2, 8'h34, 8'h06, 8'h00});
        for (int i = 4; i < 10; i++) exp_q.push_back(exp_word(i));
        pulse_start();
        while (exp_q.size() > 0) begin
            get_frame(f, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || f !== e) begin
                errors++; $display("FAIL retry_frame: got %h (seen=%0d) expected %h", f, got, e);
                if (!got) exp_q.delete();
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL retry_status: busy=%b done=%b error=%b expected 0/1/0", busy, done, error);
        end
        nack_left = 0;
    endtask

    task automatic test_nack_addr();
        logic [25:0] f, e;
        bit got, ok;
        nack_addr = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 8'h34, 16'h0000});
        pulse_start();
        while (exp_q.size() > 0) begin
            get_frame(f, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || f !== e) begin
                errors++; $display("FAIL nack_addr_frame: got %h (seen=%0d) expected %h", f, got, e);
                if (!got) exp_q.delete();
            end
        end
        wait_idle(ok);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL nack_error: got %b expected 1", error); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL nack_done: got %b expected 0", done); end
        checks++;
        if (i2c_sdat_oe !== 1'b0 || i2c_sclk !== 1'b1) begin
            errors++; $display("FAIL nack_bus: oe=%b scl=%b expected 0/1", i2c_sdat_oe, i2c_sclk);
        end
        repeat (600) @(negedge clk18);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL nack_attempts: extra frames=%0d expected 0", obs_q.size());
        end
        nack_addr = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [25:0] f, e;
        bit got, ok;
        pulse_start();
        repeat (100) @(negedge clk18);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        reset = 1'b1;
        @(posedge clk18);
        #1;
        checks++;
        if (i2c_sclk !== 1'b1 || i2c_sdat_oe !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_release: scl=%b oe=%b busy=%b expected 1/0/0", i2c_sclk, i2c_sdat_oe, busy);
        end
        @(negedge clk18);
        @(negedge clk18);
        reset = 1'b0;
        repeat (50) @(negedge clk18);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL mid_reset_stop: frames=%0d expected 0", obs_q.size());
        end
        for (int i = 0; i < 10; i++) exp_q.push_back(exp_word(i));
        pulse_start();
        while (exp_q.size() > 0) begin
            get_frame(f, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || f !== e) begin
                errors++; $display("FAIL restart_frame: got %h (seen=%0d) expected %h", f, got, e);
                if (!got) exp_q.delete();
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || done !== 1'b1) begin
            errors++; $display("FAIL restart_done: busy=%b done=%b expected 0/1", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_vol_before_done();
        test_table();
        test_vol();
        test_start_and_vol();
        test_nack_retry();
        test_nack_addr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
